byte_packer: RTL and testbench
==============================

// Module: byte_packer
// PURPOSE
//  Downstream neighbour of the 8-bit valid/ready skid stage. Consumes its byte
//  stream and packs LANES bytes into one wide word for the wide datapath.
//  Short final words are flushed on last_s, with a per-lane keep mask.
//  Both sides use valid/ready; a transfer occurs on a clk edge where valid && ready.
// PARAMETERS
//  LANES  4  bytes per output word; integer >= 2; data_d width = 8*LANES
//  CW     $clog2(LANES)  localparam; lane counter width
// PORTS
//  clk      in   1        clock; all logic on posedge
//  rst_n    in   1        asynchronous, active-low reset
//  valid_s  in   1        source byte valid
//  data_s   in   8        source byte
//  last_s   in   1        byte is the final byte of a packet; qualified by valid_s
//  ready_s  out  1        packer accepts a byte this cycle
//  valid_d  out  1        packed word valid
//  data_d   out  8*LANES  packed word
//  keep_d   out  LANES    1 = lane holds a real byte; contiguous from lane 0
//  last_d   out  1        word ends a packet
//  ready_d  in   1        destination accepts the word
// BEHAVIOUR
//  - Reset (async assert, sync release): cnt=0, accumulator=0, valid_d=0,
//    data_d=0, keep_d=0, last_d=0. Partial word is discarded, not flushed.
//  - ready_s = rst_n && (!valid_d || ready_d). Combinational on ready_d and the
//    output register only; never depends on valid_s/last_s. 1 the cycle after reset.
//  - State is the lane counter cnt (0..LANES-1): EMPTY (cnt==0), FILL (cnt>0).
//    Byte accept: byte written to lane cnt, keep bit cnt set.
//      accept && !last_s && cnt<LANES-1 : cnt <= cnt+1 (EMPTY->FILL / FILL->FILL).
//      accept && (last_s || cnt==LANES-1): word complete; load output register
//        with accumulator+new byte, keep mask, last_d<=last_s; cnt<=0,
//        accumulator/keep cleared (->EMPTY).
//  - Latency: word valid_d=1 on the edge after the completing byte is accepted.
//  - Unused lanes of a short word read 0 in data_d; keep_d never 0 when valid_d=1.
//  - Output register: held stable (data_d/keep_d/last_d) while valid_d && !ready_d.
//    On valid_d && ready_d: reload if a word completes the same edge (valid_d
//    stays 1), else valid_d<=0. Full throughput: 1 byte/clk, 1 word per LANES clk.
//  - last_s on lane LANES-1 yields a full word with last_d=1; no extra empty word.
//  - valid_s without ready_s: no state change; source must hold byte.
//  - Reset mid-operation: outputs drop to reset values immediately (async).
// CONFIGURATION
//  Macro PACKER_MSB_FIRST_EN.
//  Undefined: byte k of a word -> data_d[8k+7:8k], keep_d[k] (little-endian).
//  Defined: byte k -> data_d[8(LANES-1-k)+7 : 8(LANES-1-k)], keep_d[LANES-1-k];
//    short words are MSB-aligned, low unused lanes 0. Timing/handshake unchanged.
// TESTING (LANES=4, macro undefined unless stated)
//  1 Bytes 11,22,33,44 back-to-back, ready_d=1 -> 1 clk after 4th accept:
//    valid_d=1, data_d=32'h44332211, keep_d=4'hF, last_d=0, for exactly 1 clk.
//  2 Packet A1..A6, last_s on A6 -> 32'hA4A3A2A1/keep F/last 0, then
//    32'h0000A6A5/keep 4'b0011/last 1.
//  3 Word pending, ready_d=0 for 5 clk -> ready_s=0, data_d stable, no byte taken;
//    ready_d->1 -> ready_s=1 same cycle, streaming resumes without byte loss.
//  4 Single byte 5A with last_s -> data_d=32'h0000005A, keep_d=4'b0001, last_d=1.
//  5 Bytes 01,02 then rst_n pulsed low -> valid_d=0 at once; then 03,04,05,06 ->
//    32'h06050403 keep F (no stale 01/02).
//  6 PACKER_MSB_FIRST_EN defined: 11,22,33,44 -> 32'h11223344; 1-byte last 5A ->
//    32'h5A000000, keep_d=4'b1000.

Source files
------------

// File: rtl/byte_packer.sv
// Packs a valid/ready byte stream into LANES-byte words. The word is valid one clock after its completing byte is accepted.
// Backpressure: ready_s drops whenever a word is held unaccepted. Lane order is little-endian unless PACKER_MSB_FIRST_EN is defined.
module byte_packer #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_s,
  input  logic [7:0]           data_s,
  input  logic                 last_s,
  output logic                 ready_s,
  output logic                 valid_d,
  output logic [8*LANES-1:0]   data_d,
  output logic [LANES-1:0]     keep_d,
  output logic                 last_d,
  input  logic                 ready_d
);

  localparam int CW = $clog2(LANES);

  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [8*LANES-1:0] r_acc;
  logic [8*LANES-1:0] w_acc_nxt;
  logic [8*LANES-1:0] w_acc_fill;
  logic [LANES-1:0]   r_keep;
  logic [LANES-1:0]   w_keep_nxt;
  logic [LANES-1:0]   w_keep_fill;
  logic               r_vld;
  logic               r_last;
  logic [8*LANES-1:0] r_dat;
  logic [LANES-1:0]   r_kp;
  logic               w_accept;
  logic               w_complete;
  logic [CW-1:0]      w_lane;

  // A byte may only enter when the output slot is free or drains this edge.
  assign ready_s    = rst_n && (!r_vld || ready_d);
  assign w_accept   = valid_s && ready_s;
  assign w_complete = w_accept && (last_s || (r_cnt == CW'(LANES-1)));

`ifdef PACKER_MSB_FIRST_EN
  assign w_lane = CW'(LANES-1) - r_cnt;
`else
  assign w_lane = r_cnt;
`endif

  always_comb begin
    w_acc_fill              = r_acc;
    w_keep_fill             = r_keep;
    w_acc_fill[8*w_lane +: 8] = data_s;
    w_keep_fill[w_lane]     = 1'b1;
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_acc_nxt  = r_acc;
    w_keep_nxt = r_keep;
    if (w_complete) begin
      w_cnt_nxt  = '0;
      w_acc_nxt  = '0;
      w_keep_nxt = '0;
    end else if (w_accept) begin
      w_cnt_nxt  = r_cnt + CW'(1);
      w_acc_nxt  = w_acc_fill;
      w_keep_nxt = w_keep_fill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_keep <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_acc  <= w_acc_nxt;
      r_keep <= w_keep_nxt;
    end
  end

  // A completing byte implies the slot is free, so reload takes priority over drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_dat  <= '0;
      r_kp   <= '0;
      r_last <= 1'b0;
    end else if (w_complete) begin
      r_vld  <= 1'b1;
      r_dat  <= w_acc_fill;
      r_kp   <= w_keep_fill;
      r_last <= last_s;
    end else if (ready_d) begin
      r_vld  <= 1'b0;
    end
  end

  assign valid_d = r_vld;
  assign data_d  = r_dat;
  assign keep_d  = r_kp;
  assign last_d  = r_last;

endmodule

// File: tb/tb_byte_packer.sv
// Random and directed stimulus for byte_packer, checked against a packet-level queue model.
module tb_byte_packer;
  localparam int LANES = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } wd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_s = 1'b0;
  logic [7:0]  data_s = '0;
  logic        last_s = 1'b0;
  logic        ready_s;
  logic        valid_d;
  logic [31:0] data_d;
  logic [3:0]  keep_d;
  logic        last_d;
  logic        ready_d = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] cur[$];
  wd_t        exp_q[$];
  logic       prev_stall = 1'b0;
  logic [36:0] prev_out;

  byte_packer #(.LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .valid_s(valid_s), .data_s(data_s), .last_s(last_s),
    .ready_s(ready_s), .valid_d(valid_d), .data_d(data_d), .keep_d(keep_d),
    .last_d(last_d), .ready_d(ready_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wd_t pack_word(input int n);
    wd_t w;
    int lane;
    w = '0;
    for (int k = 0; k < n; k++) begin
`ifdef PACKER_MSB_FIRST_EN
      lane = LANES - 1 - k;
`else
      lane = k;
`endif
      w.d[8*lane +: 8] = cur[k];
      w.k[lane] = 1'b1;
    end
    return w;
  endfunction

  // Monitor: transfers are sampled mid-cycle, inputs only change just after posedge.
  always @(negedge clk) begin
    wd_t w;
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      chk("ready_s", ready_s, !valid_d || ready_d);
      if (valid_d) chk("keep_nonzero", keep_d != 0, 1);
      if (prev_stall) begin
        chk("stall_valid", valid_d, 1);
        chk("stall_hold", {data_d, keep_d, last_d}, prev_out);
      end
      prev_stall <= valid_d && !ready_d;
      prev_out   <= {data_d, keep_d, last_d};
      if (valid_d && ready_d) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("word_data", data_d, w.d);
          chk("word_keep", keep_d, w.k);
          chk("word_last", last_d, w.l);
        end
      end
      if (valid_s && ready_s) begin
        cur.push_back(data_s);
        if (last_s || cur.size() == LANES) begin
          w = pack_word(cur.size());
          w.l = last_s;
          exp_q.push_back(w);
          cur.delete();
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [7:0] b, input logic l);
    bit ok;
    ok = 0;
    valid_s = 1'b1; data_s = b; last_s = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ready_s) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    valid_s = 1'b0; last_s = 1'b0;
  endtask

  task automatic resync();
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    chk("rst_valid", valid_d, 0);
    chk("rst_data", data_d, 0);
    chk("rst_keep", keep_d, 0);
    chk("rst_last", last_d, 0);
    chk("rst_ready_s", ready_s, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", ready_s, 1);
    resync();

`ifdef PACKER_MSB_FIRST_EN
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    @(negedge clk);
    chk("msb_full_data", data_d, 32'h11223344);
    chk("msb_full_keep", keep_d, 4'hF);
    resync();
    send(8'h5A, 1);
    @(negedge clk);
    chk("msb_short_data", data_d, 32'h5A000000);
    chk("msb_short_keep", keep_d, 4'b1000);
    chk("msb_short_last", last_d, 1);
    resync();
`else
    // Full word latency and single-cycle valid.
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    @(negedge clk);
    chk("t1_valid", valid_d, 1);
    chk("t1_data", data_d, 32'h44332211);
    chk("t1_keep", keep_d, 4'hF);
    chk("t1_last", last_d, 0);
    @(negedge clk);
    chk("t1_valid_drop", valid_d, 0);
    resync();

    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
    @(negedge clk);
    chk("t2_w0_data", data_d, 32'hA4A3A2A1);
    resync();
    send(8'hA5, 0); send(8'hA6, 1);
    @(negedge clk);
    chk("t2_w1_data", data_d, 32'h0000A6A5);
    chk("t2_w1_keep", keep_d, 4'b0011);
    chk("t2_w1_last", last_d, 1);
    resync();

    // Backpressure hold and release.
    ready_d = 1'b0;
    send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 0);
    valid_s = 1'b1; data_s = 8'h55;
    repeat (5) begin
      @(negedge clk);
      chk("t3_ready_low", ready_s, 0);
      chk("t3_data_hold", data_d, 32'hB4B3B2B1);
    end
    @(posedge clk); #1 ready_d = 1'b1;
    @(negedge clk);
    chk("t3_ready_back", ready_s, 1);
    resync();
    valid_s = 1'b0;
    send(8'h66, 0); send(8'h77, 0); send(8'h88, 1);
    @(negedge clk);
    chk("t3_resume_data", data_d, 32'h88776655);
    resync();

    send(8'h5A, 1);
    @(negedge clk);
    chk("t4_data", data_d, 32'h0000005A);
    chk("t4_keep", keep_d, 4'b0001);
    chk("t4_last", last_d, 1);
    resync();

    // Async reset clears a pending word immediately.
    ready_d = 1'b0;
    send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", valid_d, 0);
    chk("t5_async_data", data_d, 0);
    @(posedge clk); #1 rst_n = 1'b1; ready_d = 1'b1;
    resync();

    send(8'h01, 0); send(8'h02, 0);
    #2 rst_n = 1'b0;
    #1 chk("t5_rst_valid", valid_d, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    resync();
    send(8'h03, 0); send(8'h04, 0); send(8'h05, 0); send(8'h06, 0);
    @(negedge clk);
    chk("t5_data", data_d, 32'h06050403);
    chk("t5_keep", keep_d, 4'hF);
    resync();
`endif

    // Random phase: source holds its byte until it is taken.
    for (int c = 0; c < 3000; c++) begin
      bit took;
      @(negedge clk);
      took = valid_s && ready_s;
      @(posedge clk); #1;
      if (!valid_s || took) begin
        valid_s = ($urandom_range(0, 3) != 0);
        data_s  = 8'($urandom);
        last_s  = ($urandom_range(0, 4) == 0);
      end
      ready_d = ($urandom_range(0, 9) < 7);
    end
    valid_s = 1'b0; last_s = 1'b0; ready_d = 1'b1;
    resync();
    send(8'hEE, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
